game_status: RTL and testbench

GAME_STATUS -- requirements
Module: game_status

---
 rtl/game_status.sv | 143 ++++++++++++++
 tb/tb_game_status.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_status.sv
// Collision/status engine: on each frame tick, scans every spike and apple hitbox
// against the player, one object per cycle, and resolves Dead / Win / play.
module game_status #(
    parameter int NUM_SPIKES = 24,
    parameter int NUM_APPLES = 4,
    parameter int MAN_SIZE   = 20,
    parameter int SPIKE_SIZE = 20,
    parameter int APPLE_SIZE = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  FrameTick,
    input  logic                  Restart,
    input  logic [9:0]            ManX,
    input  logic [9:0]            ManY,
    input  logic [9:0]            SpikeX [0:NUM_SPIKES-1],
    input  logic [9:0]            SpikeY [0:NUM_SPIKES-1],
    input  logic [9:0]            AppleX [0:NUM_APPLES-1],
    input  logic [9:0]            AppleY [0:NUM_APPLES-1],
    output logic                  Dead,
    output logic                  Win,
    output logic [NUM_APPLES-1:0] AppleGot,
    output logic                  ScanBusy
);

    localparam int NUM_OBJ = NUM_SPIKES + NUM_APPLES;
    localparam int IDXW    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_OBJ - 1);

    localparam logic [1:0] PLAY = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DEAD = 2'd2;
    localparam logic [1:0] WIN  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic                  hitSpike_q, hitSpike_d;
    logic [NUM_APPLES-1:0] appleGot_q, appleGot_d;
    logic                  frameTick_q;
    logic                  dead_q, win_q, scanBusy_q;

    logic                  tickEdge;
    logic [9:0]            objX, objY;
    logic [10:0]           objSize;
    logic                  isApple;
    logic [NUM_APPLES-1:0] appleSel;
    logic                  overlap;

    assign tickEdge = FrameTick & ~frameTick_q;

    // Select the object addressed by the scan index; spikes first, then apples.
    always_comb begin
        objX     = '0;
        objY     = '0;
        appleSel = '0;
        for (int i = 0; i < NUM_SPIKES; i++) begin
            if (idx_q == IDXW'(i)) begin
                objX = SpikeX[i];
                objY = SpikeY[i];
            end
        end
        for (int j = 0; j < NUM_APPLES; j++) begin
            if (idx_q == IDXW'(NUM_SPIKES + j)) begin
                objX        = AppleX[j];
                objY        = AppleY[j];
                appleSel[j] = 1'b1;
            end
        end
    end

    assign isApple = |appleSel;
    assign objSize = isApple ? 11'(APPLE_SIZE) : 11'(SPIKE_SIZE);

    // Strict inequalities: hitboxes that merely share an edge do not collide.
    assign overlap = ({1'b0, ManX} < ({1'b0, objX} + objSize)) &&
                     ({1'b0, objX} < ({1'b0, ManX} + 11'(MAN_SIZE))) &&
                     ({1'b0, ManY} < ({1'b0, objY} + objSize)) &&
                     ({1'b0, objY} < ({1'b0, ManY} + 11'(MAN_SIZE)));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hitSpike_d = hitSpike_q;
        appleGot_d = appleGot_q;
        case (state_q)
            PLAY: begin
                if (tickEdge) begin
                    state_d    = SCAN;
                    idx_d      = '0;
                    hitSpike_d = 1'b0;
                end
            end
            SCAN: begin
                if (overlap && !isApple) hitSpike_d = 1'b1;
                if (overlap) appleGot_d = appleGot_q | appleSel;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    // A spike hit outranks completing the apple set in the same scan.
                    if (hitSpike_d)       state_d = DEAD;
                    else if (&appleGot_d) state_d = WIN;
                    else                  state_d = PLAY;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DEAD, WIN: begin
                if (Restart) begin
                    state_d    = PLAY;
                    appleGot_d = '0;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= PLAY;
            idx_q       <= '0;
            hitSpike_q  <= 1'b0;
            appleGot_q  <= '0;
            frameTick_q <= 1'b0;
            dead_q      <= 1'b0;
            win_q       <= 1'b0;
            scanBusy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hitSpike_q  <= hitSpike_d;
            appleGot_q  <= appleGot_d;
            frameTick_q <= FrameTick;
            dead_q      <= (state_d == DEAD);
            win_q       <= (state_d == WIN);
            scanBusy_q  <= (state_d == SCAN);
        end
    end

    assign Dead     = dead_q;
    assign Win      = win_q;
    assign AppleGot = appleGot_q;
    assign ScanBusy = scanBusy_q;

endmodule

// File: tb/tb_game_status.sv
// Scoreboard bench for game_status: frames are predicted by a geometric model and
// checked by a monitor when each scan completes.
module tb_game_status;

    localparam int NS       = 24;
    localparam int NA       = 4;
    localparam int SCAN_LEN = NS + NA;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic           FrameTick = 1'b0;
    logic           Restart = 1'b0;
    logic [9:0]     ManX, ManY;
    logic [9:0]     SpikeX [NS];
    logic [9:0]     SpikeY [NS];
    logic [9:0]     AppleX [NA];
    logic [9:0]     AppleY [NA];
    logic           Dead, Win, ScanBusy;
    logic [NA-1:0]  AppleGot;

    typedef struct packed {
        logic          dead;
        logic          win;
        logic [NA-1:0] got;
    } exp_t;

    exp_t           sbQueue [$];
    int             compared = 0;
    int             mismatched = 0;
    logic [NA-1:0]  modelGot = '0;
    int             modelMode = 0;

    game_status dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .FrameTick(FrameTick),
        .Restart  (Restart),
        .ManX     (ManX),
        .ManY     (ManY),
        .SpikeX   (SpikeX),
        .SpikeY   (SpikeY),
        .AppleX   (AppleX),
        .AppleY   (AppleY),
        .Dead     (Dead),
        .Win      (Win),
        .AppleGot (AppleGot),
        .ScanBusy (ScanBusy)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Two axis-aligned squares collide when their open intervals intersect on both axes.
    function automatic bit boxesCollide(input int mx, input int my, input int ox, input int oy, input int sz);
        return (mx < ox + sz) && (ox < mx + 20) && (my < oy + sz) && (oy < my + 20);
    endfunction

    task automatic placeAllFar();
        for (int i = 0; i < NS; i++) begin SpikeX[i] = 10'd400; SpikeY[i] = 10'd400; end
        for (int j = 0; j < NA; j++) begin AppleX[j] = 10'd400; AppleY[j] = 10'd400; end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sbQueue.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (sbQueue.size() != 0) begin
            checkOutput("scan_timeout", 0, 1);
            sbQueue.delete();
        end
        repeat (35) @(negedge Clk);
    endtask

    // Predict the frame outcome, then issue the tick; frames outside play expect no scan.
    task automatic applyStimulus();
        bit            hit = 1'b0;
        logic [NA-1:0] g = modelGot;
        if (modelMode == 0) begin
            for (int i = 0; i < NS; i++)
                if (boxesCollide(ManX, ManY, SpikeX[i], SpikeY[i], 20)) hit = 1'b1;
            for (int j = 0; j < NA; j++)
                if (boxesCollide(ManX, ManY, AppleX[j], AppleY[j], 16)) g[j] = 1'b1;
            modelGot  = g;
            modelMode = hit ? 1 : ((&g) ? 2 : 0);
            sbQueue.push_back('{dead: hit, win: (!hit && (&g)), got: g});
        end
        @(negedge Clk);
        FrameTick = 1'b1;
        repeat (3) @(negedge Clk);
        FrameTick = 1'b0;
        waitIdle();
    endtask

    task automatic applyRestart();
        @(negedge Clk);
        Restart = 1'b1;
        @(negedge Clk);
        Restart = 1'b0;
        if (modelMode != 0) begin
            modelMode = 0;
            modelGot  = '0;
        end
        checkOutput("restart_dead", int'(Dead), 0);
        checkOutput("restart_win", int'(Win), 0);
        checkOutput("restart_got", int'(AppleGot), int'(modelGot));
    endtask

    // Monitor: each falling edge of ScanBusy is one completed scan to score.
    initial begin
        int   busyLen = 0;
        logic prevBusy = 1'b0;
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                busyLen  = 0;
                prevBusy = 1'b0;
            end else if (ScanBusy) begin
                busyLen++;
                prevBusy = 1'b1;
            end else if (prevBusy) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_scan", 1, 0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("scan_len", busyLen, SCAN_LEN);
                    checkOutput("dead", int'(Dead), int'(e.dead));
                    checkOutput("win", int'(Win), int'(e.win));
                    checkOutput("apple_got", int'(AppleGot), int'(e.got));
                end
                busyLen  = 0;
                prevBusy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: actual running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        ManX = 10'd100;
        ManY = 10'd100;
        placeAllFar();
        repeat (3) @(negedge Clk);
        checkOutput("reset_dead", int'(Dead), 0);
        checkOutput("reset_win", int'(Win), 0);
        checkOutput("reset_got", int'(AppleGot), 0);
        checkOutput("reset_busy", int'(ScanBusy), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        applyStimulus();

        SpikeX[5] = 10'd110; SpikeY[5] = 10'd110;
        applyStimulus();
        applyStimulus();
        checkOutput("dead_hold", int'(Dead), 1);
        checkOutput("dead_no_scan", int'(ScanBusy), 0);
        applyRestart();
        placeAllFar();

        SpikeX[0] = 10'd120; SpikeY[0] = 10'd100;
        applyStimulus();
        SpikeX[0] = 10'd119;
        applyStimulus();
        applyRestart();
        placeAllFar();

        for (int j = 0; j < NA; j++) begin
            AppleX[j] = 10'(200 * j + 50);
            AppleY[j] = 10'd600;
        end
        ManX = AppleX[0] + 10'd5; ManY = 10'd605;
        applyStimulus();
        applyRestart();
        checkOutput("play_restart_keeps_got", int'(AppleGot), 1);
        for (int j = 1; j < NA; j++) begin
            ManX = AppleX[j] + 10'd5;
            applyStimulus();
        end
        applyRestart();

        for (int j = 0; j < NA - 1; j++) begin
            ManX = AppleX[j] + 10'd5;
            applyStimulus();
        end
        SpikeX[23] = AppleX[3] + 10'd8; SpikeY[23] = 10'd608;
        ManX = AppleX[3] + 10'd3;
        applyStimulus();
        applyRestart();
        placeAllFar();

        AppleX[1] = 10'd100; AppleY[1] = 10'd100;
        ManX = 10'd100; ManY = 10'd100;
        @(negedge Clk);
        FrameTick = 1'b1;
        n = 0;
        while (!ScanBusy && n < 10) begin
            @(negedge Clk);
            n++;
        end
        checkOutput("midscan_started", int'(ScanBusy), 1);
        repeat (26) @(posedge Clk);
        #2;
        checkOutput("got_before_reset", int'(AppleGot[1]), 1);
        Reset_n = 1'b0;
        #1;
        checkOutput("midscan_reset_got", int'(AppleGot), 0);
        checkOutput("midscan_reset_busy", int'(ScanBusy), 0);
        checkOutput("midscan_reset_dead", int'(Dead), 0);
        modelMode = 0;
        modelGot  = '0;
        FrameTick = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        applyStimulus();
        applyRestart();

        for (int k = 0; k < 40; k++) begin
            ManX = 10'($urandom_range(60, 200));
            ManY = 10'($urandom_range(60, 200));
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    SpikeX[i] = 10'($urandom_range(40, 220));
                    SpikeY[i] = 10'($urandom_range(40, 220));
                end else begin
                    SpikeX[i] = 10'($urandom_range(500, 1000));
                    SpikeY[i] = 10'($urandom_range(500, 1000));
                end
            end
            for (int j = 0; j < NA; j++) begin
                AppleX[j] = 10'($urandom_range(40, 220));
                AppleY[j] = 10'($urandom_range(40, 220));
            end
            applyStimulus();
            if (modelMode != 0) applyRestart();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
